// File: rtl/cfg_pkg.sv
// Shared types and helpers for the configuration scan-chain loader.
package cfg_pkg;

  localparam int CFG_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    SHIFT_LO  = 3'd2,
    SHIFT_HI  = 3'd3,
    DONE      = 3'd4
  } cfg_state_t;

  // Number of host bytes needed to fill a chain of chain_len bits.
  function automatic int cfg_num_bytes(input int chain_len);
    return (chain_len + CFG_BYTE_W - 1) / CFG_BYTE_W;
  endfunction

endpackage

// File: rtl/cfg_clk_div.sv
// Phase timer for prog_clk: phase_done_o marks the last clk cycle of a CLK_DIV-long phase.
module cfg_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic phase_done_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_done_o = (cnt_q == CW'(CLK_DIV - 1));

  // Holding restart_i high parks the counter at zero between phases.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Serializes host bytes MSB-first onto the configuration scan chain with a divided prog_clk.
// Optional readback of the previous chain contents via prog_out: define CFG_READBACK_EN.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 80,
  parameter int CLK_DIV   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CFG_BYTE_W-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  prog_clk,
  output logic                  prog_en,
  output logic                  prog_in,
  input  logic                  prog_out,
  output logic                  busy,
  output logic                  done,
`ifdef CFG_READBACK_EN
  output logic [CFG_BYTE_W-1:0] rb_data,
  output logic                  rb_valid,
`endif
  output cfg_state_t            dbg_state
);

  localparam int CW = $clog2(CHAIN_LEN + 1);

  // Handshake: a byte moves only in a cycle where s_valid && s_ready are both high;
  // s_ready is high only in WAIT_BYTE and drops in an abort cycle so no byte is taken then.
  cfg_state_t    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [6:0]    shreg_q, shreg_d;
  logic          prog_clk_q, prog_clk_d;
  logic          prog_en_q, prog_en_d;
  logic          prog_in_q, prog_in_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          phase_done;
  logic          div_restart;
  logic          sample_en;

  assign s_ready   = (state_q == WAIT_BYTE) && !abort;
  assign prog_clk  = prog_clk_q;
  assign prog_en   = prog_en_q;
  assign prog_in   = prog_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

  assign div_restart = !((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) || phase_done;

  cfg_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart_i   (div_restart),
    .phase_done_o(phase_done)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    prog_clk_d = prog_clk_q;
    prog_en_d  = prog_en_q;
    prog_in_d  = prog_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sample_en  = 1'b0;
    if (abort) begin
      state_d    = IDLE;
      prog_clk_d = 1'b0;
      prog_en_d  = 1'b0;
      prog_in_d  = 1'b0;
      busy_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = WAIT_BYTE;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
            prog_en_d = 1'b1;
          end
        end
        WAIT_BYTE: begin
          if (s_valid) begin
            shreg_d   = s_data[6:0];
            bit_idx_d = 3'd7;
            prog_in_d = s_data[7];
            state_d   = SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_done) begin
            state_d    = SHIFT_HI;
            prog_clk_d = 1'b1;
            sample_en  = 1'b1;
          end
        end
        SHIFT_HI: begin
          if (phase_done) begin
            prog_clk_d = 1'b0;
            bit_cnt_d  = bit_cnt_q + CW'(1);
            // Trailing bits of the last byte are dropped once the chain is full.
            if (bit_cnt_q == CW'(CHAIN_LEN - 1)) begin
              state_d = DONE;
            end else if (bit_idx_q == 3'd0) begin
              state_d = WAIT_BYTE;
            end else begin
              bit_idx_d = bit_idx_q - 3'd1;
              prog_in_d = shreg_q[6];
              shreg_d   = {shreg_q[5:0], 1'b0};
              state_d   = SHIFT_LO;
            end
          end
        end
        DONE: begin
          state_d   = IDLE;
          prog_en_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      prog_clk_q <= 1'b0;
      prog_en_q  <= 1'b0;
      prog_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      prog_clk_q <= prog_clk_d;
      prog_en_q  <= prog_en_d;
      prog_in_q  <= prog_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef CFG_READBACK_EN
  logic [6:0]            rb_sh_q, rb_sh_d;
  logic [2:0]            rb_cnt_q, rb_cnt_d;
  logic [CFG_BYTE_W-1:0] rb_data_q, rb_data_d;
  logic                  rb_valid_q, rb_valid_d;
  logic [CFG_BYTE_W-1:0] rb_assembled;

  assign rb_data      = rb_data_q;
  assign rb_valid     = rb_valid_q;
  assign rb_assembled = {rb_sh_q, prog_out};

  // prog_out is taken the cycle before prog_clk rises, i.e. before the chain shifts.
  always_comb begin
    rb_sh_d    = rb_sh_q;
    rb_cnt_d   = rb_cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    if (abort || (state_q == IDLE)) begin
      rb_sh_d  = '0;
      rb_cnt_d = '0;
    end else if (sample_en) begin
      if ((rb_cnt_q == 3'd7) || (bit_cnt_q == CW'(CHAIN_LEN - 1))) begin
        rb_data_d  = rb_assembled << (3'd7 - rb_cnt_q);
        rb_valid_d = 1'b1;
        rb_sh_d    = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_sh_d  = rb_assembled[6:0];
        rb_cnt_d = rb_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_sh_q    <= '0;
      rb_cnt_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_sh_q    <= rb_sh_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end
`else
  logic unused_rb;
  assign unused_rb = prog_out ^ sample_en;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader with a behavioural scan-chain model on prog_clk/prog_en/prog_in/prog_out.
module tb_cfg_chain_loader;
  import cfg_pkg::*;

  localparam int CHAIN_LEN = 12;
  localparam int CLK_DIV   = 2;
  localparam int NB        = cfg_num_bytes(CHAIN_LEN);
  localparam int REM       = CHAIN_LEN - 8 * (NB - 1);

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready, prog_clk, prog_en, prog_in, prog_out, busy, done;
  cfg_state_t dbg_state;
`ifdef CFG_READBACK_EN
  logic [7:0] rb_data;
  logic       rb_valid;
`endif

  always #5 clk = ~clk;

  cfg_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .prog_clk (prog_clk),
    .prog_en  (prog_en),
    .prog_in  (prog_in),
    .prog_out (prog_out),
    .busy     (busy),
    .done     (done),
`ifdef CFG_READBACK_EN
    .rb_data  (rb_data),
    .rb_valid (rb_valid),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scan chain model ----------------
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  logic                 preload = 1'b0;
  logic [CHAIN_LEN-1:0] exp_chain = '0;

  always @(posedge prog_clk or posedge preload) begin
    if (preload)      chain <= preload_val;
    else if (prog_en) chain <= {chain[CHAIN_LEN-2:0], prog_in};
  end
  assign prog_out = chain[CHAIN_LEN-1];

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic       exp_q[$];
  logic [7:0] rb_exp_q[$];

  // ---------------- monitor ----------------
  logic clk_prev = 1'b0;
  int   rises = 0, hi_len = 0, lo_len = 0, cyc = 0, last_fall_cyc = -100;
  int   done_cnt = 0, hs_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      clk_prev = 1'b0;
      hi_len   = 0;
      lo_len   = 0;
    end else begin
      if (s_valid && s_ready) hs_cnt++;
      if (s_ready) lo_len = 0;
      if (prog_clk && !clk_prev) begin
        rises++;
        chk("lo_len", lo_len, CLK_DIV);
        chk("en_at_rise", prog_en, 1);
        if (exp_q.size() > 0) chk("prog_in", prog_in, exp_q.pop_front());
        else                  chk("unexpected_edge", prog_clk, 0);
        hi_len = 1;
        lo_len = 0;
      end else if (prog_clk) begin
        hi_len++;
      end
      if (!prog_clk && clk_prev) begin
        chk("hi_len", hi_len, CLK_DIV);
        last_fall_cyc = cyc;
        lo_len = 0;
      end
      if (!prog_clk && prog_en && !s_ready) lo_len++;
      if (done) begin
        done_cnt++;
        chk("done_after_fall", cyc - last_fall_cyc, 1);
        chk("done_busy", busy, 0);
        chk("done_en", prog_en, 0);
      end
`ifdef CFG_READBACK_EN
      if (rb_valid) begin
        if (rb_exp_q.size() > 0) chk("rb_data", rb_data, rb_exp_q.pop_front());
        else                     chk("rb_unexpected", rb_valid, 0);
      end
`endif
      clk_prev = prog_clk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    rb_exp_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic push_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      exp_q.push_back(b[7-i]);
      exp_chain = {exp_chain[CHAIN_LEN-2:0], b[7-i]};
    end
  endtask

  // Expected readback is the current model chain content, tail first.
  task automatic push_rb();
    logic [7:0] acc;
    int k;
    acc = '0;
    k = 0;
    for (int i = CHAIN_LEN - 1; i >= 0; i--) begin
      acc[7-k] = chain[i];
      k++;
      if ((k == 8) || (i == 0)) begin
        rb_exp_q.push_back(acc);
        acc = '0;
        k = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, input int stall);
    logic ok;
    if (stall > 0) begin
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (s_ready) begin ok = 1'b1; break; end
      end
      chk("wait_ready_timeout", ok, 1);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_clk", prog_clk, 0);
        chk("stall_en", prog_en, 1);
      end
      @(posedge clk);
      #1;
    end
    s_data  = b;
    s_valid = 1'b1;
    push_bits(b, nbits);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    chk("hs_timeout", ok, 1);
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] b0, input logic [7:0] b1, input int stall,
                          input logic mid_start);
    int d0, r0, h0;
    logic ok;
    flush();
    push_rb();
    d0 = done_cnt;
    r0 = rises;
    h0 = hs_cnt;
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("en_after_start", prog_en, 1);
    chk("ready_after_start", s_ready, 1);
    send_byte(b0, 8, 0);
    if (mid_start) pulse_start();
    send_byte(b1, REM, stall);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    chk("done_timeout", ok, 1);
    tick(4);
    chk("done_count", done_cnt - d0, 1);
    chk("edges", rises - r0, CHAIN_LEN);
    chk("handshakes", hs_cnt - h0, NB);
    chk("chain", chain, exp_chain);
    chk("sb_empty", exp_q.size(), 0);
`ifdef CFG_READBACK_EN
    chk("rb_empty", rb_exp_q.size(), 0);
`endif
    chk("idle_busy", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, r0, r1;
    logic ok;

    preload_val = 12'hC35;
    #1 preload = 1'b1;
    #1 preload = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_prog_clk", prog_clk, 0);
    chk("rst_prog_en", prog_en, 0);
    chk("rst_prog_in", prog_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef CFG_READBACK_EN
    chk("rst_rb_valid", rb_valid, 0);
    chk("rst_rb_data", rb_data, 0);
`endif
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Basic load, host always valid; readback sees preloaded 0xC35.
    run_load(8'hA5, 8'h3F, 0, 1'b0);

    // Host underflow before the second byte.
    run_load(8'h5A, 8'hC6, 20, 1'b0);

    // start pulsed while busy must be ignored.
    run_load(8'h3C, 8'h96, 0, 1'b1);

    // start together with abort in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_en", prog_en, 0);
    tick(2);
    chk("sa_ready", s_ready, 0);

    // Abort after the 5th rising edge.
    flush();
    d0 = done_cnt;
    r0 = rises;
    pulse_start();
    send_byte(8'h12, 8, 0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (rises - r0 >= 5) begin ok = 1'b1; break; end
    end
    chk("abort_wait_timeout", ok, 1);
    rb_exp_q.delete();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort_en", prog_en, 0);
    chk("abort_clk", prog_clk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", s_ready, 0);
    exp_q.delete();
    tick(10);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_edges", rises - r0, 5);
    run_load(8'hFF, 8'hFF, 0, 1'b0);
    chk("reload_chain", chain, 12'hFFF);

    // Asynchronous reset in the middle of a high phase.
    flush();
    r0 = rises;
    pulse_start();
    send_byte(8'h81, 8, 0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (prog_clk && (rises - r0 >= 2)) begin ok = 1'b1; break; end
    end
    chk("rst_wait_timeout", ok, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clk", prog_clk, 0);
    chk("mid_rst_en", prog_en, 0);
    chk("mid_rst_in", prog_in, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_done", done, 0);
    r1 = rises;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("in_rst_clk", prog_clk, 0);
    end
    flush();
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_en", prog_en, 0);
    chk("post_rst_edges", rises - r1, 0);
    run_load(8'h69, 8'hE7, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
